dbus_router: RTL and testbench
==============================

# dbus_router

Routes data-bus requests from the pipeline's memory stage either to the DCache (cached) or to a single-beat uncached cbus path, based on the MIPS segment of the virtual address. It sits directly upstream of the DCache and translates addresses with the fixed kseg0/kseg1 mapping. It keeps `data_ok` returns in issue order across both paths.

## Interface
Parameters:
- `MAX_CACHED_OUTSTANDING`, default 2: maximum cached requests accepted but not yet answered with `data_ok`; range 1..3.

Ports:
- `clk` in 1: single clock, rising edge.
- `resetn` in 1: reset, asynchronous, active-low.
- `dreq` in `dbus_req_t`: request from the memory stage; `addr` is virtual.
- `dresp` out `dbus_resp_t`: response to the memory stage.
- `cdreq` out `dbus_req_t`: request to the DCache; `addr` is physical.
- `cdresp` in `dbus_resp_t`: DCache response.
- `ucreq` out `cbus_req_t`: uncached request to the cbus arbiter.
- `ucresp` in `cbus_resp_t`: uncached cbus response.

## Operation
- **Address translation** (combinational on `dreq.addr`):
  - `[31:29]=100` (kseg0): paddr = addr − 0x8000_0000; cached.
  - `[31:29]=101` (kseg1): paddr = addr − 0xA000_0000; uncached.
  - Any other address: paddr = addr; cached.
- **Cached path:**
  - `cdreq` = `dreq` with `addr` replaced by paddr.
  - `cdreq.valid` = `dreq.valid & cached & ustate==U_IDLE & cnt<MAX_CACHED_OUTSTANDING`.
  - `dresp.addr_ok` = `cdresp.addr_ok & cdreq.valid`.
  - 2-bit counter `cnt`: increments on a cached addr handshake and decrements on `cdresp.data_ok`; both in the same cycle leaves it unchanged.
- **Uncached FSM** with states U_IDLE, U_REQ, U_RESP:
  - U_IDLE → U_REQ when `dreq.valid & uncached & cnt==0`. In that cycle `dresp.addr_ok=1`, and paddr, size, strobe, data and the write flag (`|strobe`) are latched.
  - U_REQ: `ucreq.valid=1`, `is_write`=latched flag, `addr`=latched paddr, `size`=latched size, `len=MLEN1`, `strobe`/`data` latched. On `ucresp.ready & ucresp.last`: latch `ucresp.data` and go to U_RESP.
  - U_RESP: `dresp.data_ok=1` and `dresp.data`=latched data, for exactly one cycle; then U_IDLE.
- **Response mux:** `dresp.data_ok` = `cdresp.data_ok | ustate==U_RESP`. `dresp.data` comes from the uncached register in U_RESP, otherwise from `cdresp.data`.
- **Ordering:**
  - Uncached requests are accepted only when `cnt==0`.
  - Cached requests are accepted only in U_IDLE.
  - Therefore the two `data_ok` sources never assert in the same cycle. The bench checks this with an assertion.
- **Reset (async, any time):** `ustate`=U_IDLE, `cnt`=0, latches cleared. Outputs read 0: `ucreq.valid`, `dresp.addr_ok`, `dresp.data_ok`, `cdreq.valid`.

## Timing
- Cached path:
  - Zero added latency; `addr_ok` and `data_ok` pass through combinationally.
  - A request with `cnt==MAX` is held (`addr_ok=0`) until a `data_ok` decrements `cnt`. The decrement is visible on the next cycle.
- Uncached path:
  - `addr_ok` in cycle 0.
  - `ucreq.valid` from cycle 1.
  - The ready+last handshake occurs in cycle k≥1; `data_ok` follows in cycle k+1.
  - Minimum total latency is 2 cycles.
  - `ucreq` fields are stable while `valid`=1.
- An uncached request that arrives while `cnt>0` waits. It is accepted in the first cycle after `cnt` reaches 0, never in the same cycle as the final `data_ok`.
- In U_RESP, no new request of either kind is accepted; the next acceptance happens in U_IDLE.

## Configuration
- `DBUS_UNCACHED_EN`:
  - **Defined:** behaviour as above.
  - **Undefined:** kseg1 is still translated (−0xA000_0000) but treated as cached. The FSM is removed, `ucreq.valid` is tied 0, and `ucresp` is ignored.

## Test plan
- **Cached kseg0 read:** read of 0x8000_1234 → `cdreq.addr=0x0000_1234`, `cdreq.valid=1`; the DCache `addr_ok`/`data_ok` pass through unchanged, and `ucreq.valid` stays 0.
- **Uncached kseg1 write:**
  - Stimulus: write 0xBFC0_0010, strobe 4'hF, data 0xDEAD_BEEF, with `ucresp.ready&last` in cycle 3.
  - Required: `addr_ok` in cycle 0; `ucreq` with addr 0x1FC0_0010, `is_write=1`, `len=MLEN1` during cycles 1-3; `data_ok` only in cycle 4.
- **Uncached read ordering:**
  - Stimulus: two cached reads (`cnt`=2), then an uncached read of 0xA000_0000.
  - Required: the uncached `addr_ok` is held low until both cached `data_ok`s have occurred and `cnt==0`. The uncached `data_ok` returns data 0x1234_5678 from `ucresp`.
- **Outstanding limit:** three back-to-back cached requests with the DCache delaying `data_ok` → the third gets `addr_ok=0` until the first `data_ok`, then is accepted the next cycle.
- **Reset mid-transaction:** assert `resetn=0` asynchronously in U_REQ → `ucreq.valid` drops immediately without a clock, and after release `cnt=0` and state is U_IDLE.
- **Macro off:** without `DBUS_UNCACHED_EN`, a read of 0xA000_0040 → `cdreq.addr=0x0000_0040`, `cdreq.valid=1`, and `ucreq.valid` stays 0.

Source files
------------

// File: rtl/dbus_pkg.sv
// Shared data-bus and cbus request/response types used by dbus_router and its bench.
package dbus_pkg;

  typedef enum logic [2:0] {
    MSIZE1 = 3'd0,
    MSIZE2 = 3'd1,
    MSIZE4 = 3'd2
  } msize_t;

  typedef enum logic [3:0] {
    MLEN1  = 4'd0,
    MLEN2  = 4'd1,
    MLEN4  = 4'd3,
    MLEN8  = 4'd7,
    MLEN16 = 4'd15
  } mlen_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    msize_t      size;
    logic [3:0]  strobe;
    logic [31:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } dbus_resp_t;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    msize_t      size;
    logic [31:0] addr;
    logic [3:0]  strobe;
    logic [31:0] data;
    mlen_t       len;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] data;
  } cbus_resp_t;

endpackage

// File: rtl/dbus_router.sv
// dbus_router: routes memory-stage data-bus requests to the DCache or to a single-beat
// uncached cbus path, keeping data_ok in issue order. Define DBUS_UNCACHED_EN to enable the uncached path.
module dbus_router
  import dbus_pkg::*;
#(
  parameter int MAX_CACHED_OUTSTANDING = 2
) (
  input  logic       clk,
  input  logic       resetn,
  input  dbus_req_t  dreq,
  output dbus_resp_t dresp,
  output dbus_req_t  cdreq,
  input  dbus_resp_t cdresp,
  output cbus_req_t  ucreq,
  input  cbus_resp_t ucresp
);

  localparam logic [1:0] MAX_CNT = 2'(MAX_CACHED_OUTSTANDING);

  logic [31:0] paddr_s;
  logic        seg_uncached_s;
  logic        uncached_s;
  logic        u_idle_s;
  logic        u_resp_s;
  logic        uc_accept_s;
  logic [31:0] urdata_s;
  logic        cached_hs_s;
  logic [1:0]  cnt_d;
  logic [1:0]  cnt_q;

  always_comb begin
    paddr_s        = dreq.addr;
    seg_uncached_s = 1'b0;
    case (dreq.addr[31:29])
      3'b100: paddr_s = dreq.addr - 32'h8000_0000;
      3'b101: begin
        paddr_s        = dreq.addr - 32'hA000_0000;
        seg_uncached_s = 1'b1;
      end
      default: paddr_s = dreq.addr;
    endcase
  end

`ifdef DBUS_UNCACHED_EN
  typedef enum logic [1:0] {
    U_IDLE = 2'd0,
    U_REQ  = 2'd1,
    U_RESP = 2'd2
  } ustate_e;

  ustate_e     ustate_d, ustate_q;
  logic [31:0] uaddr_d, uaddr_q;
  logic [31:0] uwdata_d, uwdata_q;
  logic [31:0] urdata_d, urdata_q;
  msize_t      usize_d, usize_q;
  logic [3:0]  ustrobe_d, ustrobe_q;
  logic        uwrite_d, uwrite_q;

  assign uncached_s  = seg_uncached_s;
  assign u_idle_s    = (ustate_q == U_IDLE);
  assign u_resp_s    = (ustate_q == U_RESP);
  // Uncached requests wait for every cached request to drain so data_ok stays in order.
  assign uc_accept_s = dreq.valid & uncached_s & u_idle_s & (cnt_q == 2'd0);
  assign urdata_s    = urdata_q;

  always_comb begin
    ustate_d  = ustate_q;
    uaddr_d   = uaddr_q;
    uwdata_d  = uwdata_q;
    urdata_d  = urdata_q;
    usize_d   = usize_q;
    ustrobe_d = ustrobe_q;
    uwrite_d  = uwrite_q;
    case (ustate_q)
      U_IDLE: begin
        if (uc_accept_s) begin
          ustate_d  = U_REQ;
          uaddr_d   = paddr_s;
          uwdata_d  = dreq.data;
          usize_d   = dreq.size;
          ustrobe_d = dreq.strobe;
          uwrite_d  = |dreq.strobe;
        end else begin
          ustate_d = U_IDLE;
        end
      end
      U_REQ: begin
        if (ucresp.ready & ucresp.last) begin
          ustate_d = U_RESP;
          urdata_d = ucresp.data;
        end else begin
          ustate_d = U_REQ;
        end
      end
      U_RESP:  ustate_d = U_IDLE;
      default: ustate_d = U_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ustate_q  <= U_IDLE;
      uaddr_q   <= 32'h0;
      uwdata_q  <= 32'h0;
      urdata_q  <= 32'h0;
      usize_q   <= MSIZE1;
      ustrobe_q <= 4'h0;
      uwrite_q  <= 1'b0;
    end else begin
      ustate_q  <= ustate_d;
      uaddr_q   <= uaddr_d;
      uwdata_q  <= uwdata_d;
      urdata_q  <= urdata_d;
      usize_q   <= usize_d;
      ustrobe_q <= ustrobe_d;
      uwrite_q  <= uwrite_d;
    end
  end

  // Every cbus field comes straight from a flop, so it is stable while valid is high.
  always_comb begin
    ucreq          = '0;
    ucreq.valid    = (ustate_q == U_REQ);
    ucreq.is_write = uwrite_q;
    ucreq.size     = usize_q;
    ucreq.addr     = uaddr_q;
    ucreq.strobe   = ustrobe_q;
    ucreq.data     = uwdata_q;
    ucreq.len      = MLEN1;
  end
`else
  logic unused_s;

  // kseg1 is still translated but served by the DCache; the cbus side is inert.
  assign uncached_s  = 1'b0;
  assign u_idle_s    = 1'b1;
  assign u_resp_s    = 1'b0;
  assign uc_accept_s = 1'b0;
  assign urdata_s    = 32'h0;
  assign unused_s    = ^{ucresp, seg_uncached_s};

  always_comb begin
    ucreq     = '0;
    ucreq.len = MLEN1;
  end
`endif

  always_comb begin
    cdreq       = dreq;
    cdreq.addr  = paddr_s;
    cdreq.valid = dreq.valid & ~uncached_s & u_idle_s & (cnt_q < MAX_CNT);
  end

  assign cached_hs_s = cdreq.valid & cdresp.addr_ok;

  always_comb begin
    dresp         = '0;
    dresp.addr_ok = cached_hs_s | uc_accept_s;
    dresp.data_ok = cdresp.data_ok | u_resp_s;
    dresp.data    = u_resp_s ? urdata_s : cdresp.data;
  end

  always_comb begin
    cnt_d = cnt_q;
    case ({cached_hs_s, cdresp.data_ok})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= 2'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_dbus_router.sv
// Directed self-checking bench for dbus_router; uncached scenarios run when DBUS_UNCACHED_EN is defined.
module tb_dbus_router;
  import dbus_pkg::*;

  logic       clk = 1'b0;
  logic       resetn;
  dbus_req_t  dreq;
  dbus_resp_t dresp;
  dbus_req_t  cdreq;
  dbus_resp_t cdresp;
  cbus_req_t  ucreq;
  cbus_resp_t ucresp;
  int tests = 0;
  int fails = 0;

  dbus_router #(.MAX_CACHED_OUTSTANDING(2)) dut (
    .clk    (clk),
    .resetn (resetn),
    .dreq   (dreq),
    .dresp  (dresp),
    .cdreq  (cdreq),
    .cdresp (cdresp),
    .ucreq  (ucreq),
    .ucresp (ucresp)
  );

  always #5 clk = ~clk;

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic v, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    dreq.valid  = v;
    dreq.addr   = a;
    dreq.size   = MSIZE4;
    dreq.strobe = s;
    dreq.data   = d;
  endtask

  task automatic dc(input logic aok, input logic dok, input logic [31:0] d);
    cdresp.addr_ok = aok;
    cdresp.data_ok = dok;
    cdresp.data    = d;
  endtask

  task automatic uc(input logic rdy, input logic lst, input logic [31:0] d);
    ucresp.ready = rdy;
    ucresp.last  = lst;
    ucresp.data  = d;
  endtask

`ifdef DBUS_UNCACHED_EN
  always @(negedge clk) begin
    if (resetn === 1'b1 && cdresp.data_ok === 1'b1) begin
      assert (dut.ustate_q != 2'd2) else $error("FAIL data_ok_overlap: both data_ok sources active");
    end
  end
`endif

  initial begin
    resetn = 1'b0;
    req(1'b0, 32'h0, 4'h0, 32'h0);
    dc(1'b0, 1'b0, 32'h0);
    uc(1'b0, 1'b0, 32'h0);
    #11;
    chk1("rst_addr_ok", dresp.addr_ok, 1'b0);
    chk1("rst_data_ok", dresp.data_ok, 1'b0);
    chk1("rst_cdreq_valid", cdreq.valid, 1'b0);
    chk1("rst_ucreq_valid", ucreq.valid, 1'b0);
    #1 resetn = 1'b1;

    // Cached kseg0 read with pass-through handshakes
    step();
    req(1'b1, 32'h8000_1234, 4'h0, 32'h0);
    dc(1'b1, 1'b0, 32'h0);
    #1;
    chk32("k0_paddr", cdreq.addr, 32'h0000_1234);
    chk1("k0_cdvalid", cdreq.valid, 1'b1);
    chk1("k0_addr_ok", dresp.addr_ok, 1'b1);
    chk1("k0_no_data_ok", dresp.data_ok, 1'b0);
    chk1("k0_ucvalid", ucreq.valid, 1'b0);
    step();
    req(1'b0, 32'h0, 4'h0, 32'h0);
    dc(1'b0, 1'b1, 32'hCAFE_0001);
    #1;
    chk1("k0_data_ok", dresp.data_ok, 1'b1);
    chk32("k0_data", dresp.data, 32'hCAFE_0001);
    chk1("k0_idle_addr_ok", dresp.addr_ok, 1'b0);
    step();

    // Untranslated segments and write field pass-through, DCache not ready
    req(1'b1, 32'h0040_0008, 4'h3, 32'h1111_2222);
    dc(1'b0, 1'b0, 32'h0);
    #1;
    chk32("kuseg_paddr", cdreq.addr, 32'h0040_0008);
    chk32("wr_strobe", {28'h0, cdreq.strobe}, 32'h0000_0003);
    chk32("wr_data", cdreq.data, 32'h1111_2222);
    chk1("wr_cdvalid", cdreq.valid, 1'b1);
    chk1("wr_not_ready", dresp.addr_ok, 1'b0);
    req(1'b1, 32'hC000_0010, 4'h0, 32'h0);
    #1;
    chk32("kseg2_paddr", cdreq.addr, 32'hC000_0010);

    // Outstanding limit of two cached requests
    step();
    req(1'b1, 32'h8000_0100, 4'h0, 32'h0);
    dc(1'b1, 1'b0, 32'h0);
    #1;
    chk1("lim_req1", dresp.addr_ok, 1'b1);
    step();
    req(1'b1, 32'h8000_0104, 4'h0, 32'h0);
    #1;
    chk1("lim_req2", dresp.addr_ok, 1'b1);
    step();
    req(1'b1, 32'h8000_0108, 4'h0, 32'h0);
    #1;
    chk1("lim_req3_held", dresp.addr_ok, 1'b0);
    chk1("lim_req3_cdvalid", cdreq.valid, 1'b0);
    step();
    dc(1'b1, 1'b1, 32'hD000_0001);
    #1;
    chk1("lim_held_at_data_ok", dresp.addr_ok, 1'b0);
    chk32("lim_data1", dresp.data, 32'hD000_0001);
    step();
    dc(1'b1, 1'b0, 32'h0);
    #1;
    chk1("lim_req3_accept", dresp.addr_ok, 1'b1);
    step();
    req(1'b0, 32'h0, 4'h0, 32'h0);
    dc(1'b0, 1'b1, 32'hD000_0002);
    step();
    // Simultaneous accept and data_ok keeps the count at one
    req(1'b1, 32'h8000_010C, 4'h0, 32'h0);
    dc(1'b1, 1'b1, 32'hD000_0003);
    #1;
    chk1("same_cycle_accept", dresp.addr_ok, 1'b1);
    step();
    req(1'b1, 32'h8000_0110, 4'h0, 32'h0);
    dc(1'b1, 1'b0, 32'h0);
    #1;
    chk1("cnt1_accept", dresp.addr_ok, 1'b1);
    step();
    req(1'b1, 32'h8000_0114, 4'h0, 32'h0);
    #1;
    chk1("cnt2_held", dresp.addr_ok, 1'b0);
    req(1'b0, 32'h0, 4'h0, 32'h0);
    dc(1'b0, 1'b1, 32'h0);
    step();
    step();
    dc(1'b0, 1'b0, 32'h0);

`ifndef DBUS_UNCACHED_EN
    // kseg1 served by the DCache when the uncached path is compiled out
    req(1'b1, 32'hA000_0040, 4'h0, 32'h0);
    dc(1'b1, 1'b0, 32'h0);
    uc(1'b1, 1'b1, 32'hFFFF_FFFF);
    #1;
    chk32("off_paddr", cdreq.addr, 32'h0000_0040);
    chk1("off_cdvalid", cdreq.valid, 1'b1);
    chk1("off_addr_ok", dresp.addr_ok, 1'b1);
    chk1("off_ucvalid", ucreq.valid, 1'b0);
    step();
    req(1'b0, 32'h0, 4'h0, 32'h0);
    dc(1'b0, 1'b1, 32'h0000_0040);
    #1;
    chk1("off_ucvalid_after", ucreq.valid, 1'b0);
    chk32("off_data", dresp.data, 32'h0000_0040);
    step();
    dc(1'b0, 1'b0, 32'h0);
    uc(1'b0, 1'b0, 32'h0);
`else
    // Uncached kseg1 write, ready+last in cycle 3
    req(1'b1, 32'hBFC0_0010, 4'hF, 32'hDEAD_BEEF);
    dc(1'b1, 1'b0, 32'h0);
    #1;
    chk1("uw_c0_addr_ok", dresp.addr_ok, 1'b1);
    chk1("uw_c0_cdvalid", cdreq.valid, 1'b0);
    chk1("uw_c0_ucvalid", ucreq.valid, 1'b0);
    step();
    req(1'b0, 32'h0, 4'h0, 32'h0);
    dc(1'b0, 1'b0, 32'h0);
    #1;
    chk1("uw_c1_valid", ucreq.valid, 1'b1);
    chk32("uw_c1_addr", ucreq.addr, 32'h1FC0_0010);
    chk1("uw_c1_is_write", ucreq.is_write, 1'b1);
    chk32("uw_c1_len", {28'h0, ucreq.len}, 32'h0000_0000);
    chk32("uw_c1_size", {29'h0, ucreq.size}, 32'h0000_0002);
    chk32("uw_c1_data", ucreq.data, 32'hDEAD_BEEF);
    chk32("uw_c1_strobe", {28'h0, ucreq.strobe}, 32'h0000_000F);
    chk1("uw_c1_data_ok", dresp.data_ok, 1'b0);
    step();
    #1;
    chk1("uw_c2_valid", ucreq.valid, 1'b1);
    chk1("uw_c2_data_ok", dresp.data_ok, 1'b0);
    step();
    uc(1'b1, 1'b1, 32'h0);
    #1;
    chk1("uw_c3_valid", ucreq.valid, 1'b1);
    chk32("uw_c3_addr", ucreq.addr, 32'h1FC0_0010);
    chk1("uw_c3_data_ok", dresp.data_ok, 1'b0);
    step();
    uc(1'b0, 1'b0, 32'h0);
    req(1'b1, 32'h8000_0000, 4'h0, 32'h0);
    dc(1'b1, 1'b0, 32'h0);
    #1;
    chk1("uw_c4_data_ok", dresp.data_ok, 1'b1);
    chk1("uw_c4_ucvalid", ucreq.valid, 1'b0);
    chk1("uw_c4_no_accept", dresp.addr_ok, 1'b0);
    step();
    #1;
    chk1("uw_c5_data_ok", dresp.data_ok, 1'b0);
    chk1("uw_c5_cached_accept", dresp.addr_ok, 1'b1);
    step();
    req(1'b0, 32'h0, 4'h0, 32'h0);
    dc(1'b0, 1'b1, 32'h0);
    step();
    dc(1'b0, 1'b0, 32'h0);

    // Uncached read waits for two outstanding cached reads
    req(1'b1, 32'h8000_0200, 4'h0, 32'h0);
    dc(1'b1, 1'b0, 32'h0);
    step();
    req(1'b1, 32'h8000_0204, 4'h0, 32'h0);
    step();
    req(1'b1, 32'hA000_0000, 4'h0, 32'h0);
    dc(1'b0, 1'b1, 32'hC000_0001);
    #1;
    chk1("ord_held_cnt2", dresp.addr_ok, 1'b0);
    chk32("ord_cached_data1", dresp.data, 32'hC000_0001);
    step();
    dc(1'b0, 1'b1, 32'hC000_0002);
    #1;
    chk1("ord_held_cnt1", dresp.addr_ok, 1'b0);
    step();
    dc(1'b0, 1'b0, 32'h0);
    #1;
    chk1("ord_accept_cnt0", dresp.addr_ok, 1'b1);
    step();
    req(1'b0, 32'h0, 4'h0, 32'h0);
    uc(1'b1, 1'b1, 32'h1234_5678);
    #1;
    chk1("ord_ucvalid", ucreq.valid, 1'b1);
    chk32("ord_ucaddr", ucreq.addr, 32'h0000_0000);
    chk1("ord_is_read", ucreq.is_write, 1'b0);
    step();
    uc(1'b0, 1'b0, 32'h0);
    #1;
    chk1("ord_data_ok", dresp.data_ok, 1'b1);
    chk32("ord_data", dresp.data, 32'h1234_5678);
    step();

    // Asynchronous reset while in U_REQ
    req(1'b1, 32'hA000_0100, 4'h0, 32'h0);
    #1;
    chk1("rm_accept", dresp.addr_ok, 1'b1);
    step();
    req(1'b1, 32'h8000_0300, 4'h0, 32'h0);
    dc(1'b1, 1'b0, 32'h0);
    #1;
    chk1("rm_ucvalid", ucreq.valid, 1'b1);
    chk1("rm_cached_blocked", cdreq.valid, 1'b0);
    #1 resetn = 1'b0;
    #1;
    chk1("rm_ucvalid_async", ucreq.valid, 1'b0);
    req(1'b0, 32'h0, 4'h0, 32'h0);
    dc(1'b0, 1'b0, 32'h0);
    step();
    resetn = 1'b1;
    #1;
    req(1'b1, 32'hA000_0200, 4'h0, 32'h0);
    #1;
    chk1("rm_idle_cnt0_accept", dresp.addr_ok, 1'b1);
    req(1'b0, 32'h0, 4'h0, 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
